alu_result_buf: RTL and testbench

ALU_RESULT_BUF -- requirements
Module: alu_result_buf

---
 rtl/alu_result_buf.sv | 126 ++++++++++++
 tb/tb_alu_result_buf.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buf.sv
// FIFO buffer of ALU results (result, flags, opcode) with sticky flag accumulation.
// Optional overflow trap enabled by defining ALU_RESULT_BUF_VTRAP_EN.
module alu_result_buf #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_result,
    input  logic [3:0]                 in_flags,
    input  logic [2:0]                 in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic [3:0]                 out_flags,
    output logic [2:0]                 out_op,
    output logic [$clog2(DEPTH):0]     count,
    output logic [3:0]                 sticky,
    input  logic                       clr_sticky
`ifdef ALU_RESULT_BUF_VTRAP_EN
    ,
    output logic                       trap,
    input  logic                       trap_clr
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   res_mem_q  [DEPTH];
    logic [3:0]    flag_mem_q [DEPTH];
    logic [2:0]    op_mem_q   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [3:0]    sticky_q, sticky_d;
    logic          push, pop;

`ifdef ALU_RESULT_BUF_VTRAP_EN
    logic trap_q, trap_d;
    logic trap_hit;

    assign trap_hit = push && (in_op[2:1] == 2'b11) && in_flags[0];
    assign trap     = trap_q;
    assign in_ready = (count_q != CW'(DEPTH)) && !trap_q;
`else
    assign in_ready = (count_q != CW'(DEPTH));
`endif

    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head fields come straight from the storage registers; no bypass path.
    assign out_result = res_mem_q[rd_ptr_q];
    assign out_flags  = flag_mem_q[rd_ptr_q];
    assign out_op     = op_mem_q[rd_ptr_q];
    assign count      = count_q;
    assign sticky     = sticky_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sticky_d = sticky_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            sticky_d = sticky_q | in_flags;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Clearing wins over a same-cycle push's flags.
        if (clr_sticky) begin
            sticky_d = '0;
        end
    end

`ifdef ALU_RESULT_BUF_VTRAP_EN
    always_comb begin
        trap_d = trap_q;
        if (trap_hit) begin
            trap_d = 1'b1;
        end else if (trap_clr) begin
            trap_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= '0;
`ifdef ALU_RESULT_BUF_VTRAP_EN
            trap_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
`ifdef ALU_RESULT_BUF_VTRAP_EN
            trap_q   <= trap_d;
`endif
        end
    end

    // Storage is data-only: written on push, never reset.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            res_mem_q[wr_ptr_q]  <= in_result;
            flag_mem_q[wr_ptr_q] <= in_flags;
            op_mem_q[wr_ptr_q]   <= in_op;
        end
    end

endmodule

// File: tb/tb_alu_result_buf.sv
// Directed self-checking bench for alu_result_buf (DEPTH=4).
// Trap scenario runs when ALU_RESULT_BUF_VTRAP_EN is defined.
module tb_alu_result_buf;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_flags;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic [2:0]  out_op;
    logic [2:0]  count;
    logic [3:0]  sticky;
    logic        clr_sticky;
`ifdef ALU_RESULT_BUF_VTRAP_EN
    logic        trap;
    logic        trap_clr;
`endif

    int checks   = 0;
    int failures = 0;

    alu_result_buf #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_op     (out_op),
        .count      (count),
        .sticky     (sticky),
        .clr_sticky (clr_sticky)
`ifdef ALU_RESULT_BUF_VTRAP_EN
        ,
        .trap       (trap),
        .trap_clr   (trap_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (sticky !== 4'b0000) begin failures++; $display("FAIL reset_sticky got=%b exp=0000", sticky); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_result = 32'h0000_0005;
        in_flags  = 4'b0000;
        in_op     = 3'b110;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_result !== 32'h0000_0005) begin failures++; $display("FAIL single_result got=%h exp=00000005", out_result); end
        checks++; if (out_op !== 3'b110) begin failures++; $display("FAIL single_op got=%b exp=110", out_op); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", count); end
        step();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_result = 32'(i + 1);
            in_flags  = 4'b0000;
            in_op     = 3'(i);
            step();
        end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        in_result = 32'd99;
        step();
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_fifth_ignored got=%0d exp=4", count); end
        checks++; if (out_result !== 32'd1) begin failures++; $display("FAIL fill_head_stable got=%0d exp=1", out_result); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== 32'(i + 1) || out_op !== 3'(i)) begin
                failures++;
                $display("FAIL fill_order[%0d] got=%0d/%b/%0d exp=%0d/1/%0d", i, out_result, out_valid, out_op, i + 1, i);
            end
            step();
        end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL fill_drained got=%0d exp=0", count); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_flags  = 4'b0000;
        in_op     = 3'b001;
        for (int i = 0; i < 2; i++) begin
            in_result = 32'(100 + i);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_result = 32'(102 + i);
            checks++;
            if (out_result !== 32'(100 + i)) begin
                failures++; $display("FAIL b2b_order[%0d] got=%0d exp=%0d", i, out_result, 100 + i);
            end
            step();
            checks++;
            if (count !== 3'd2) begin
                failures++; $display("FAIL b2b_count[%0d] got=%0d exp=2", i, count);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_result !== 32'(110 + i)) begin
                failures++; $display("FAIL b2b_tail[%0d] got=%0d exp=%0d", i, out_result, 110 + i);
            end
            step();
        end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL b2b_drained got=%0d exp=0", count); end
    endtask

    task automatic test_sticky();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = 3'b000;
        in_result = 32'hA;
        in_flags  = 4'b1000;
        step();
        in_flags  = 4'b0010;
        step();
        checks++; if (sticky !== 4'b1010) begin failures++; $display("FAIL sticky_accum got=%b exp=1010", sticky); end
        in_flags   = 4'b0100;
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        in_valid   = 1'b0;
        checks++; if (sticky !== 4'b0000) begin failures++; $display("FAIL sticky_clr_priority got=%b exp=0000", sticky); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL sticky_push_kept got=%0d exp=1", count); end
        checks++; if (out_flags !== 4'b0100) begin failures++; $display("FAIL sticky_head_flags got=%b exp=0100", out_flags); end
        step();
        checks++; if (sticky !== 4'b0000 || count !== 3'd0) begin failures++; $display("FAIL sticky_hold got=%b/%0d exp=0000/0", sticky, count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'b010;
        for (int i = 0; i < 3; i++) begin
            in_result = 32'(200 + i);
            in_flags  = 4'b0001;
            step();
        end
        checks++; if (count !== 3'd3 || sticky !== 4'b0001) begin failures++; $display("FAIL mid_prefill got=%0d/%b exp=3/0001", count, sticky); end
        reset     = 1'b1;
        in_flags  = 4'b1111;
        out_ready = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        checks++; if (sticky !== 4'b0000) begin failures++; $display("FAIL mid_sticky got=%b exp=0000", sticky); end
        step();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL empty_pop_ignored got=%0d exp=0", count); end
    endtask

    task automatic test_overflow_op();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'h77;
        in_op     = 3'b111;
        in_flags  = 4'b0001;
        step();
        in_valid = 1'b0;
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL ovf_push_count got=%0d exp=1", count); end
`ifdef ALU_RESULT_BUF_VTRAP_EN
        checks++; if (trap !== 1'b1) begin failures++; $display("FAIL trap_set got=%b exp=1", trap); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL trap_in_ready got=%b exp=0", in_ready); end
        in_valid = 1'b1;
        in_op    = 3'b000;
        step();
        in_valid = 1'b0;
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL trap_blocks_push got=%0d exp=1", count); end
        out_ready = 1'b1;
        step();
        checks++; if (count !== 3'd0 || trap !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL trap_drain got=%0d/%b/%b exp=0/1/0", count, trap, in_ready);
        end
        trap_clr = 1'b1;
        step();
        trap_clr = 1'b0;
        checks++; if (trap !== 1'b0) begin failures++; $display("FAIL trap_clr got=%b exp=0", trap); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL trap_clr_ready got=%b exp=1", in_ready); end
`else
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ovf_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_result !== 32'h77 || out_op !== 3'b111) begin failures++; $display("FAIL ovf_head got=%h/%b exp=77/111", out_result, out_op); end
        out_ready = 1'b1;
        step();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL ovf_drain got=%0d exp=0", count); end
`endif
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_result  = '0;
        in_flags   = '0;
        in_op      = '0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
`ifdef ALU_RESULT_BUF_VTRAP_EN
        trap_clr   = 1'b0;
`endif
        #1;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_sticky();
        test_reset_mid();
        test_overflow_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
